rpn_stack_engine: RTL and testbench
===================================

# rpn_stack_engine

Parametrised postfix (RPN) evaluator that replaces the fixed 32-bit calculator stage behind the infix-to-postfix converter in the expression parser. It consumes a token stream (operands and operators) over a strobe/acknowledge handshake and keeps operands on an internal stack of configurable width and depth. It emits one result per END token together with an error code. Error coverage: stack overflow, stack underflow, divide-by-zero, leftover operands and illegal opcodes.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- DEPTH, 16, stack entries (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- input_stb  in  1  token valid; held until input_ack seen
- input_data  in  WIDTH  operand value, or opcode in [2:0] when operator
- is_input_operator  in  1  1 = input_data carries an opcode
- input_ack  out  1  one-cycle token-accepted pulse
- output_stb  out  1  result valid; held until output_ack
- output_data  out  WIDTH  result (0 on error)
- output_err  out  3  error code for this expression
- output_ack  in  1  consumer accepted result
- stack_depth  out  $clog2(DEPTH+1)  current number of stacked entries

## Operation
- Opcodes (input_data[2:0]; upper bits ignored): 0 ADD, 1 SUB (second-from-top minus top), 2 MUL (low WIDTH bits), 3 DIV, 4 MOD, 5 END, 6–7 illegal.
- Arithmetic: unsigned, modulo 2^WIDTH; wrap-around is not an error.
- Error codes:
  - 0 OK
  - 1 OVERFLOW: push while depth==DEPTH
  - 2 UNDERFLOW: binary op with depth<2, or END with depth 0
  - 3 DIV_ZERO: DIV/MOD with top==0
  - 4 LEFTOVER: END with depth>1
  - 5 BAD_OP: opcodes 6–7, or 3–4 when division is not compiled
- FSM states:
  - ACCEPT: if input_stb, latch the token → EXEC.
  - EXEC: input_ack=1.
    - Operand: push.
    - ADD/SUB/MUL: pop two, push result.
    - DIV/MOD: check zero → DIV.
    - END → EMIT.
    - Otherwise → ACCEPT.
    - Detected error: latch code → DRAIN.
  - DIV: iterative restoring divide, WIDTH cycles; pop two, push quotient or remainder → ACCEPT.
  - DRAIN: accepts and discards tokens (same two-cycle ack rhythm) until END → EMIT. Only the first error code is kept.
  - EMIT: output_stb=1, output_data = top (or 0 if error), output_err = latched code. On output_ack: clear stack, clear error → ACCEPT.
- Stack stays unchanged on an erroring token. The overflowing operand is acked and discarded.

## Timing
- Reset values:
  - input_ack=0, output_stb=0, output_data=0, output_err=0, stack_depth=0
  - state ACCEPT, error latch 0
  - Any in-flight division or pending result is discarded.
- input_ack is registered: it is high exactly one cycle, the cycle after input_stb is sampled high in ACCEPT. The producer updates stb/data after that cycle; input_stb is not re-sampled during the ack cycle.
- Throughput:
  - operand, ADD/SUB/MUL, or any token in DRAIN: 2 cycles per token
  - DIV/MOD: 2+WIDTH cycles
- Result latency: output_stb rises the cycle after the END ack pulse.
- output_stb, output_data and output_err are stable until output_ack is sampled high. output_stb is low the next cycle.
- No input_ack while in EMIT (backpressure propagates to the producer).
- output_ack while output_stb is low is ignored.
- stack_depth updates in the EXEC or final DIV cycle.

## Configuration
- RPN_DIV_EN defined:
  - DIV/MOD implemented by a WIDTH-cycle restoring divider; DIV yields the quotient, MOD the remainder.
- RPN_DIV_EN undefined:
  - no divider logic; DIV state absent.
  - opcodes 3/4 raise BAD_OP (code 5), and the token is acked after the normal 2 cycles.

## Test plan
- Basic arithmetic: tokens 3, 4, ADD, 2, MUL, END → output_data=14, output_err=0, stack_depth returns to 0 after output_ack.
- Wrap-around: WIDTH=8, tokens 200, 100, ADD, END → output_data=44, err 0.
- Division:
  - With RPN_DIV_EN: 100, 7, MOD, END → 2; 100, 7, DIV, END → 14. DIV token ack-to-next-ack spacing = WIDTH+2 cycles.
  - Without RPN_DIV_EN: the same streams give err 5, data 0.
- Errors:
  - DEPTH=4, push 1..5 then END → all tokens acked, err 1, data 0.
  - 5, ADD, END → err 2.
  - 9, 0, DIV, END → err 3.
  - 1, 2, END → err 4.
- Backpressure: hold output_ack low 10 cycles after result → output_stb, data and err stable; input_ack stays 0 while input_stb is high. Release → one output handshake, then the next token is acked.
- Mid-operation reset: assert rst during the DIV state, or while output_stb is high → all outputs 0 immediately. A fresh 6, 3, SUB, END then yields 3, err 0.

Source files
------------

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: RPN evaluator with a DEPTH-entry stack; define RPN_DIV_EN to build the DIV/MOD divider.
module rpn_stack_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         input_stb,
  input  logic [WIDTH-1:0]             input_data,
  input  logic                         is_input_operator,
  output logic                         input_ack,
  output logic                         output_stb,
  output logic [WIDTH-1:0]             output_data,
  output logic [2:0]                   output_err,
  input  logic                         output_ack,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth
);
  localparam int SW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
`ifdef RPN_DIV_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {ACCEPT, EXEC, DRAIN, EMIT, DIV} state_t;
`else
  typedef enum logic [2:0] {ACCEPT, EXEC, DRAIN, EMIT} state_t;
`endif
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [WIDTH-1:0] r_data, w_wd, w_t, w_n, w_alu;
  logic [SW-1:0] r_sp, w_sp;
  logic [AW-1:0] w_wa, w_ti, w_ni;
  logic [2:0] r_err, w_err, w_op;
  logic r_isop, r_ack, w_wr, w_end, w_take;
  assign w_op = r_data[2:0];
  assign w_end = r_isop && w_op == 3'd5;
  assign w_take = (r_state == ACCEPT || r_state == DRAIN) && input_stb;
  assign w_ti = AW'(r_sp - SW'(1));
  assign w_ni = AW'(r_sp - SW'(2));
  assign w_t = r_stk[w_ti];
  assign w_n = r_stk[w_ni];
  assign w_alu = w_op == 3'd0 ? w_n + w_t : w_op == 3'd1 ? w_n - w_t : w_n * w_t;
  assign input_ack = r_ack;
  assign output_stb = r_state == EMIT;
  assign output_data = (output_stb && r_err == 3'd0) ? w_t : '0;
  assign output_err = output_stb ? r_err : 3'd0;
  assign stack_depth = r_sp;
`ifdef RPN_DIV_EN
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_q, r_r, w_qn, w_rn;
  logic [WIDTH:0] w_rs, w_df;
  // restoring step: r_q shifts dividend bits out and quotient bits in
  assign w_rs = {r_r, r_q[WIDTH-1]};
  assign w_df = w_rs - {1'b0, w_t};
  assign w_rn = w_df[WIDTH] ? w_rs[WIDTH-1:0] : w_df[WIDTH-1:0];
  assign w_qn = {r_q[WIDTH-2:0], ~w_df[WIDTH]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_q <= '0;
      r_r <= '0;
    end else if (r_state == EXEC) begin
      r_cnt <= '0;
      r_q <= w_n;
      r_r <= '0;
    end else if (r_state == DIV) begin
      r_cnt <= r_cnt + CW'(1);
      r_q <= w_qn;
      r_r <= w_rn;
    end
`endif
  always_comb begin
    w_next = r_state;
    w_err = r_err;
    w_sp = r_sp;
    w_wr = 1'b0;
    w_wa = w_ti;
    w_wd = w_alu;
    case (r_state)
      ACCEPT, DRAIN: w_next = input_stb ? EXEC : r_state;
      EXEC: begin
        w_next = ACCEPT;
        if (r_err == 3'd0) begin
          if (!r_isop) begin
            if (r_sp == SW'(DEPTH)) w_err = 3'd1;
            else begin
              w_wr = 1'b1;
              w_wa = AW'(r_sp);
              w_wd = r_data;
              w_sp = r_sp + SW'(1);
            end
          end else if (w_op <= 3'd2) begin
            if (r_sp < SW'(2)) w_err = 3'd2;
            else begin
              w_wr = 1'b1;
              w_wa = w_ni;
              w_sp = r_sp - SW'(1);
            end
          end else if (w_end) begin
            w_err = r_sp == '0 ? 3'd2 : r_sp > SW'(1) ? 3'd4 : 3'd0;
            w_next = EMIT;
          end
`ifdef RPN_DIV_EN
          else if (w_op <= 3'd4) begin
            w_err = r_sp < SW'(2) ? 3'd2 : w_t == '0 ? 3'd3 : 3'd0;
            w_next = DIV;
          end
`endif
          else w_err = 3'd5;
        end
        if (w_err != 3'd0) w_next = w_end ? EMIT : DRAIN;
      end
`ifdef RPN_DIV_EN
      DIV: if (r_cnt == CW'(WIDTH-1)) begin
        w_next = ACCEPT;
        w_wr = 1'b1;
        w_wa = w_ni;
        w_wd = w_op == 3'd3 ? w_qn : w_rn;
        w_sp = r_sp - SW'(1);
      end
`endif
      EMIT: if (output_ack) begin
        w_next = ACCEPT;
        w_sp = '0;
        w_err = 3'd0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ACCEPT;
      r_err <= 3'd0;
      r_sp <= '0;
      r_ack <= 1'b0;
      r_data <= '0;
      r_isop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= w_err;
      r_sp <= w_sp;
      r_ack <= w_take;
      if (w_take) begin
        r_data <= input_data;
        r_isop <= is_input_operator;
      end
    end
  always_ff @(posedge clk)
    if (w_wr) r_stk[w_wa] <= w_wd;
endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb_rpn_stack_engine: directed token streams with a result scoreboard; expectations follow RPN_DIV_EN.
module tb_rpn_stack_engine;
  localparam int W = 8;
  localparam int D = 4;
  localparam int OP = 256;
  localparam int ENDT = OP + 5;
`ifdef RPN_DIV_EN
  localparam bit DV = 1'b1;
`else
  localparam bit DV = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   e;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, input_stb = 1'b0, is_input_operator = 1'b0, output_ack = 1'b0;
  logic [W-1:0] input_data = '0;
  logic input_ack, output_stb;
  logic [W-1:0] output_data;
  logic [2:0] output_err;
  logic [2:0] stack_depth;
  int total = 0, bad = 0, cyc = 0, last_ack = 0, gap = 0, n_out = 0;
  bit hold = 1'b0;
  exp_t sb[$];
  int tq[$];

  rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .input_stb(input_stb), .input_data(input_data),
    .is_input_operator(is_input_operator), .input_ack(input_ack),
    .output_stb(output_stb), .output_data(output_data), .output_err(output_err),
    .output_ack(output_ack), .stack_depth(stack_depth)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rst_zero(input string nm);
    chk({nm, "_ack"}, input_ack, 0);
    chk({nm, "_stb"}, output_stb, 0);
    chk({nm, "_data"}, output_data, 0);
    chk({nm, "_err"}, output_err, 0);
    chk({nm, "_depth"}, stack_depth, 0);
  endtask

  task automatic send(input logic op, input logic [W-1:0] d);
    int n;
    n = 0;
    input_stb = 1'b1;
    is_input_operator = op;
    input_data = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!input_ack && n < 200);
    if (!input_ack) chk("ack_timeout", input_ack, 1);
    gap = cyc - last_ack;
    last_ack = cyc;
    input_stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("result_timeout", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [W-1:0] ed, input logic [2:0] ee);
    exp_t e;
    e.d = ed;
    e.e = ee;
    sb.push_back(e);
  endtask

  task automatic expr(input logic [W-1:0] ed, input logic [2:0] ee, input bit wait_done);
    expect_res(ed, ee);
    foreach (tq[i]) send(tq[i] >= OP, W'(tq[i] >= OP ? tq[i] - OP : tq[i]));
    if (wait_done) drain();
  endtask

  task automatic wait_stb(input string nm);
    int n;
    n = 0;
    while (!output_stb && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, output_stb, 1);
  endtask

  // monitor: consume every presented result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && output_stb && !hold) begin
        if (sb.size() == 0) chk("unexpected_result", output_stb, 0);
        else begin
          e = sb.pop_front();
          chk("result_data", output_data, e.d);
          chk("result_err", output_err, e.e);
        end
        n_out++;
        output_ack = 1'b1;
        @(posedge clk);
        #1;
        output_ack = 1'b0;
        chk("stb_drop", output_stb, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int h0, n;
    repeat (2) @(posedge clk);
    #1;
    rst_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_res(14, 0);
    send(0, 3);
    send(0, 4);
    @(posedge clk);
    #1;
    chk("depth_two", stack_depth, 2);
    send(1, 0);
    send(0, 2);
    chk("gap_operand", gap, 2);
    send(1, 2);
    chk("gap_mul", gap, 2);
    send(1, 5);
    drain();
    chk("depth_cleared", stack_depth, 0);
    tq = '{200, 100, OP + 0, ENDT};          expr(44, 0, 1);
    tq = '{3, 5, OP + 1, ENDT};              expr(254, 0, 1);
    tq = '{100, 7, OP + 4, ENDT};            expr(DV ? 8'd2 : 8'd0, DV ? 3'd0 : 3'd5, 1);
    chk("mod_gap", gap, DV ? W + 2 : 2);
    tq = '{100, 7, OP + 3, ENDT};            expr(DV ? 8'd14 : 8'd0, DV ? 3'd0 : 3'd5, 1);
    tq = '{255, 16, OP + 3, ENDT};           expr(DV ? 8'd15 : 8'd0, DV ? 3'd0 : 3'd5, 1);
    tq = '{1, 2, 3, 4, 5, ENDT};             expr(0, 1, 1);
    tq = '{5, OP + 0, ENDT};                 expr(0, 2, 1);
    tq = '{ENDT};                            expr(0, 2, 1);
    tq = '{9, 0, OP + 3, ENDT};              expr(0, DV ? 3'd3 : 3'd5, 1);
    tq = '{1, 2, ENDT};                      expr(0, 4, 1);
    tq = '{1, OP + 6, ENDT};                 expr(0, 5, 1);
    tq = '{5, OP + 0, OP + 7, 3, ENDT};      expr(0, 2, 1);
    chk("depth_after_errors", stack_depth, 0);
    // backpressure: result held while a new token waits unacked
    hold = 1'b1;
    tq = '{3, 4, OP + 0, ENDT};
    expr(7, 0, 0);
    wait_stb("bp_stb_rise");
    input_stb = 1'b1;
    is_input_operator = 1'b0;
    input_data = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_stb", output_stb, 1);
      chk("bp_data", output_data, 7);
      chk("bp_err", output_err, 0);
      chk("bp_no_ack", input_ack, 0);
    end
    h0 = n_out;
    hold = 1'b0;
    n = 0;
    while (!input_ack && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_token_acked", input_ack, 1);
    chk("bp_one_handshake", n_out, h0 + 1);
    input_stb = 1'b0;
    expect_res(5, 0);
    send(1, 5);
    drain();
    // reset during a DIV/MOD token
    send(0, 100);
    send(0, 7);
    send(1, 3);
    repeat (3) @(posedge clk);
    #2;
    chk("div_depth_hold", stack_depth, 2);
    rst = 1'b1;
    #1;
    rst_zero("rst_div");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tq = '{6, 3, OP + 1, ENDT};              expr(3, 0, 1);
    // reset while a result is presented
    hold = 1'b1;
    tq = '{2, ENDT};
    expr(2, 0, 0);
    wait_stb("rst_emit_stb");
    rst = 1'b1;
    #1;
    rst_zero("rst_emit");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 1'b0;
    tq = '{8, ENDT};                         expr(8, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
